dmac_main_ctrl: RTL and testbench



---
 rtl/dmac_main_ctrl.sv | 175 +++++++++++++++++
 tb/tb_dmac_main_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dmac_main_ctrl.sv
// DMAC main control: request arbitration, 4-word config fetch over AHB, channel sequencing.
// Optional XFER watchdog is built when DMAC_CTRL_TIMEOUT_EN is defined (limit TIMEOUT_CYCLES).
module dmac_main_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] DmacReq,
  input  logic       HReady,
  input  logic [1:0] M_HResp,
  input  logic       irq,
  output logic       DmacReq_Reg_en,
  output logic       PeriAddr_reg_en,
  output logic       SAddr_Reg_en,
  output logic       DAddr_Reg_en,
  output logic       Trans_sz_Reg_en,
  output logic       Ctrl_Reg_en,
  output logic [1:0] addr_inc_sel,
  output logic [1:0] config_HTrans,
  output logic       config_write,
  output logic [1:0] con_sel,
  output logic       con_en,
  output logic       channel_en_1,
  output logic       channel_en_2,
  output logic       busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_CFG_ADDR,
    S_CFG_DATA,
    S_START,
    S_XFER,
    S_DONE,
    S_ERROR
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic       ch_q, ch_d;
  logic [3:0] cfg_en;
  logic       timeout_w;

`ifdef DMAC_CTRL_TIMEOUT_EN
  logic [31:0] wdog_q, wdog_d;

  // START always leads into XFER, so clearing there restarts the count on XFER entry.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_START) begin
      wdog_d = '0;
    end else if (state_q == S_XFER) begin
      wdog_d = wdog_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end

  assign timeout_w = (state_q == S_XFER) && (wdog_q == 32'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_w = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      ch_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ch_q    <= ch_d;
    end
  end

  assign config_write    = 1'b0;
  assign SAddr_Reg_en    = cfg_en[0];
  assign DAddr_Reg_en    = cfg_en[1];
  assign Trans_sz_Reg_en = cfg_en[2];
  assign Ctrl_Reg_en     = cfg_en[3];
  assign busy            = (state_q != S_IDLE);

  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    ch_d            = ch_q;
    DmacReq_Reg_en  = 1'b0;
    PeriAddr_reg_en = 1'b0;
    cfg_en          = 4'b0000;
    addr_inc_sel    = 2'd0;
    config_HTrans   = 2'b00;
    con_sel         = 2'b10;
    con_en          = 1'b0;
    channel_en_1    = 1'b0;
    channel_en_2    = 1'b0;
    done            = 1'b0;
    err             = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (DmacReq != 2'b00) begin
          ch_d    = DmacReq[1];
          idx_d   = 2'd0;
          state_d = S_LATCH;
        end
      end
      S_LATCH: begin
        DmacReq_Reg_en  = 1'b1;
        PeriAddr_reg_en = 1'b1;
        con_en          = 1'b1;
        state_d         = S_CFG_ADDR;
      end
      S_CFG_ADDR: begin
        config_HTrans = 2'b10;
        addr_inc_sel  = idx_q;
        if (HReady) begin
          state_d = S_CFG_DATA;
        end
      end
      S_CFG_DATA: begin
        addr_inc_sel = idx_q;
        // An ERROR response aborts regardless of HReady so a bad word is never captured.
        if (M_HResp == 2'b01) begin
          state_d = S_ERROR;
        end else if (HReady && (M_HResp == 2'b00)) begin
          cfg_en = 4'b0001 << idx_q;
          if (idx_q == 2'd3) begin
            state_d = S_START;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = S_CFG_ADDR;
          end
        end
      end
      S_START: begin
        con_sel      = {1'b0, ch_q};
        con_en       = 1'b1;
        channel_en_1 = ~ch_q;
        channel_en_2 = ch_q;
        state_d      = S_XFER;
      end
      S_XFER: begin
        con_sel      = {1'b0, ch_q};
        channel_en_1 = ~ch_q;
        channel_en_2 = ch_q;
        if (irq) begin
          state_d = S_DONE;
        end else if (timeout_w) begin
          state_d = S_ERROR;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        con_en  = 1'b1;
        state_d = S_IDLE;
      end
      S_ERROR: begin
        err     = 1'b1;
        con_en  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmac_main_ctrl.sv
// Self-checking bench for dmac_main_ctrl: directed table, randomized transactions, reset abort.
// A transaction-level model expands each transfer into its expected per-cycle output trace.
module tb_dmac_main_ctrl;
  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] DmacReq;
  logic       HReady;
  logic [1:0] M_HResp;
  logic       irq;
  logic       DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en;
  logic       Trans_sz_Reg_en, Ctrl_Reg_en;
  logic [1:0] addr_inc_sel, config_HTrans, con_sel;
  logic       config_write, con_en, channel_en_1, channel_en_2, busy, done, err;

  always #5 clk = ~clk;

  dmac_main_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .DmacReq(DmacReq), .HReady(HReady), .M_HResp(M_HResp), .irq(irq),
    .DmacReq_Reg_en(DmacReq_Reg_en), .PeriAddr_reg_en(PeriAddr_reg_en),
    .SAddr_Reg_en(SAddr_Reg_en), .DAddr_Reg_en(DAddr_Reg_en),
    .Trans_sz_Reg_en(Trans_sz_Reg_en), .Ctrl_Reg_en(Ctrl_Reg_en),
    .addr_inc_sel(addr_inc_sel), .config_HTrans(config_HTrans), .config_write(config_write),
    .con_sel(con_sel), .con_en(con_en), .channel_en_1(channel_en_1), .channel_en_2(channel_en_2),
    .busy(busy), .done(done), .err(err)
  );

  logic [18:0] obs;
  assign obs = {DmacReq_Reg_en, PeriAddr_reg_en, SAddr_Reg_en, DAddr_Reg_en, Trans_sz_Reg_en,
                Ctrl_Reg_en, addr_inc_sel, config_HTrans, config_write, con_sel, con_en,
                channel_en_1, channel_en_2, busy, done, err};

  typedef struct {
    logic [1:0]  req;
    logic        hready;
    logic [1:0]  hresp;
    logic        irq;
    logic [18:0] exp;
  } cyc_t;

  typedef struct {
    logic [1:0] req;
    int         wd1;
    int         err_word;
    int         xfer_len;
    int         busy_req;
    logic       exp_ch2;
    int         exp_en_cyc;
    logic       exp_done;
    logic       exp_err;
  } vec_t;

  cyc_t sched[$];
  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;

  function automatic logic [18:0] ev(input logic [5:0] en, input logic [1:0] asel,
                                     input logic [1:0] htrans, input logic [1:0] csel,
                                     input logic cen, input logic c1, input logic c2,
                                     input logic bsy, input logic dn, input logic er);
    return {en, asel, htrans, 1'b0, csel, cen, c1, c2, bsy, dn, er};
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] breq(input int b);
    return (b < 0) ? 2'($urandom_range(0, 3)) : 2'(b);
  endfunction

  function automatic void push(input logic [1:0] r, input logic hr, input logic [1:0] rs,
                               input logic iq, input logic [18:0] e);
    cyc_t c;
    c.req = r; c.hready = hr; c.hresp = rs; c.irq = iq; c.exp = e;
    sched.push_back(c);
  endfunction

  function automatic void chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endfunction

  // Expand one transfer into cycles: IDLE arbitration, LATCH, four address/data word
  // fetches with wait states, then START/XFER/DONE, or ERROR on a bad word or watchdog.
  task automatic build_txn(input logic [1:0] req, input int wa[4], input int wd[4],
                           input int err_word, input int xfer_len, input int busy_req,
                           input int idle_gap);
    logic       ch = req[1];
    logic [1:0] csel = {1'b0, req[1]};
    logic [18:0] idle_e = ev(6'b0, 2'd0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);
    logic [18:0] xfer_e = ev(6'b0, 2'd0, 2'b00, csel, 0, ~ch, ch, 1, 0, 0);
    logic [18:0] err_e  = ev(6'b0, 2'd0, 2'b00, 2'b10, 1, 0, 0, 1, 0, 1);
    for (int g = 0; g < idle_gap; g++) push(2'b00, rbit(), 2'b00, rbit(), idle_e);
    push(req, rbit(), 2'b00, rbit(), idle_e);
    push(breq(busy_req), rbit(), 2'b00, rbit(), ev(6'b110000, 2'd0, 2'b00, 2'b10, 1, 0, 0, 1, 0, 0));
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < wa[w]; i++)
        push(breq(busy_req), 1'b0, 2'b00, rbit(), ev(6'b0, 2'(w), 2'b10, 2'b10, 0, 0, 0, 1, 0, 0));
      push(breq(busy_req), 1'b1, 2'b00, rbit(), ev(6'b0, 2'(w), 2'b10, 2'b10, 0, 0, 0, 1, 0, 0));
      for (int i = 0; i < wd[w]; i++)
        push(breq(busy_req), 1'b0, 2'b00, rbit(), ev(6'b0, 2'(w), 2'b00, 2'b10, 0, 0, 0, 1, 0, 0));
      if (w == err_word) begin
        push(breq(busy_req), 1'b1, 2'b01, rbit(), ev(6'b0, 2'(w), 2'b00, 2'b10, 0, 0, 0, 1, 0, 0));
        push(breq(busy_req), rbit(), 2'b00, rbit(), err_e);
        return;
      end
      push(breq(busy_req), 1'b1, 2'b00, rbit(),
           ev(6'b001000 >> w, 2'(w), 2'b00, 2'b10, 0, 0, 0, 1, 0, 0));
    end
    push(breq(busy_req), rbit(), 2'b00, rbit(), ev(6'b0, 2'd0, 2'b00, csel, 1, ~ch, ch, 1, 0, 0));
    if (xfer_len < 0) begin
      for (int i = 0; i < TO; i++) push(breq(busy_req), rbit(), 2'b00, 1'b0, xfer_e);
      push(breq(busy_req), rbit(), 2'b00, rbit(), err_e);
      return;
    end
    for (int i = 0; i < xfer_len; i++) push(breq(busy_req), rbit(), 2'b00, 1'b0, xfer_e);
    push(breq(busy_req), rbit(), 2'b00, 1'b1, xfer_e);
    push(breq(busy_req), rbit(), 2'b00, rbit(), ev(6'b0, 2'd0, 2'b00, 2'b10, 1, 0, 0, 1, 1, 0));
  endtask

  task automatic run_txn(input int id, output int first_en, output logic s1, output logic s2,
                         output logic sdone, output logic serr);
    int lat = -1;
    int n = sched.size();
    first_en = 0; s1 = 0; s2 = 0; sdone = 0; serr = 0;
    for (int s = 0; s < n; s++) begin
      @(posedge clk); #1;
      DmacReq = sched[s].req; HReady = sched[s].hready;
      M_HResp = sched[s].hresp; irq = sched[s].irq;
      @(negedge clk);
      checks++;
      if (obs !== sched[s].exp) begin
        failures++;
        $display("FAIL cycle txn=%0d step=%0d got=%b want=%b", id, s, obs, sched[s].exp);
      end
      if (busy && lat < 0) lat = s;
      if ((channel_en_1 || channel_en_2) && first_en == 0 && lat >= 0) first_en = s - lat + 1;
      s1 |= channel_en_1; s2 |= channel_en_2; sdone |= done; serr |= err;
    end
    sched.delete();
    $display("txn %0d cycles=%0d first_en=%0d ch1=%0b ch2=%0b done=%0b err=%0b",
             id, n, first_en, s1, s2, sdone, serr);
  endtask

  initial begin
    int   wa[4];
    int   wd[4];
    int   fe;
    logic s1, s2, sd, se;
    logic [18:0] idle_e = ev(6'b0, 2'd0, 2'b00, 2'b10, 0, 0, 0, 0, 0, 0);

    //          req   wd1 errw xlen breq ch2 en_cyc done err
    vecs.push_back('{2'b01, 0, 4, 3, 0, 1'b0, 10, 1'b1, 1'b0});  // single request
    vecs.push_back('{2'b11, 0, 4, 2, 0, 1'b1, 10, 1'b1, 1'b0});  // simultaneous -> channel 2
    vecs.push_back('{2'b01, 2, 4, 1, 0, 1'b0, 12, 1'b1, 1'b0});  // two wait states on word 1
    vecs.push_back('{2'b01, 0, 2, 1, 0, 1'b0, 0,  1'b0, 1'b1});  // ERROR on word 2
    vecs.push_back('{2'b01, 0, 4, 5, 2, 1'b0, 10, 1'b1, 1'b0});  // DmacReq=10 held while busy
    vecs.push_back('{2'b10, 0, 4, 1, 0, 1'b1, 10, 1'b1, 1'b0});  // ...served afterwards
`ifdef DMAC_CTRL_TIMEOUT_EN
    vecs.push_back('{2'b01, 0, 4, -1, 0, 1'b0, 10, 1'b0, 1'b1});     // watchdog expiry
    vecs.push_back('{2'b10, 0, 4, TO - 1, 0, 1'b1, 10, 1'b1, 1'b0}); // irq wins on last cycle
`else
    vecs.push_back('{2'b01, 0, 4, 40, 0, 1'b0, 10, 1'b1, 1'b0});     // long XFER, no watchdog
`endif

    rst = 1'b1; DmacReq = 2'b11; HReady = 1'b1; M_HResp = 2'b00; irq = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_outputs", int'(obs), int'(idle_e));
    end
    @(posedge clk); #1;
    rst = 1'b0; DmacReq = 2'b00; irq = 1'b0;
    @(negedge clk);
    chk("post_reset_idle", int'(obs), int'(idle_e));

    for (int v = 0; v < vecs.size(); v++) begin
      wa = '{0, 0, 0, 0};
      wd = '{0, vecs[v].wd1, 0, 0};
      build_txn(vecs[v].req, wa, wd, vecs[v].err_word, vecs[v].xfer_len, vecs[v].busy_req, 0);
      run_txn(v, fe, s1, s2, sd, se);
      chk("first_en_cycle", fe, vecs[v].exp_en_cyc);
      chk("ch1_seen", int'(s1), int'(vecs[v].exp_en_cyc != 0 && !vecs[v].exp_ch2));
      chk("ch2_seen", int'(s2), int'(vecs[v].exp_en_cyc != 0 && vecs[v].exp_ch2));
      chk("done_seen", int'(sd), int'(vecs[v].exp_done));
      chk("err_seen", int'(se), int'(vecs[v].exp_err));
    end

    for (int t = 0; t < 30; t++) begin
      int ew;
      for (int w = 0; w < 4; w++) begin
        wa[w] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
        wd[w] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      end
      ew = int'($urandom_range(0, 7));
      build_txn(2'($urandom_range(1, 3)), wa, wd, (ew > 3) ? 4 : ew,
                int'($urandom_range(0, 12)), -1, int'($urandom_range(0, 2)));
      run_txn(100 + t, fe, s1, s2, sd, se);
    end

    // Reset while stalled in CFG_DATA of word 1 must abort silently.
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      DmacReq = (c == 0) ? 2'b01 : 2'b00;
      HReady  = (c == 5 || c == 6) ? 1'b0 : 1'b1;
      M_HResp = 2'b00;
      irq     = 1'b0;
      rst     = (c == 5);
      @(negedge clk);
      if (c == 5) begin
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_idx", int'(addr_inc_sel), 1);
        chk("rst_pre_htrans", int'(config_HTrans), 0);
      end
      if (c >= 6) chk("rst_abort_idle", int'(obs), int'(idle_e));
    end
    $display("txn reset_abort done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
